// File: rtl/bht_update_unit.sv
// Branch history table: 2-bit counters, two-stage update path,
// sequential table initialisation and a saturating mispredict counter.
module bht_update_unit #(
  parameter int unsigned VLEN       = 39,
  parameter int unsigned NR_ENTRIES = 64,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_bp_i,
  input  logic            debug_mode_i,
  input  logic            res_valid_i,
  input  logic [VLEN-1:0] res_pc_i,
  input  logic            res_is_branch_i,
  input  logic            res_is_taken_i,
  input  logic            res_is_mispredict_i,
  input  logic [VLEN-1:0] lookup_pc_i,
  output logic            lookup_valid_o,
  output logic            lookup_taken_o,
  output logic            ready_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int unsigned IDX = $clog2(NR_ENTRIES);

  typedef enum logic {INIT, IDLE} state_e;
  typedef logic [IDX-1:0] idx_t;

  state_e      state_q, state_d;
  idx_t        init_idx_q, init_idx_d;
  logic [1:0]  ctr_q [NR_ENTRIES];

  logic        upd_v_q, upd_v_d;
  idx_t        upd_idx_q, upd_idx_d;
  logic        upd_tk_q, upd_tk_d;

  logic [31:0] cnt_q, cnt_d;

  logic        idle;
  idx_t        res_idx;
  idx_t        lkp_idx;
  logic [1:0]  upd_ctr;
  logic        wr_en;
  idx_t        wr_idx;
  logic [1:0]  wr_data;
  logic        unused_pc;

  assign idle    = (state_q == IDLE);
  assign res_idx = res_pc_i[IDX:1];
  assign lkp_idx = lookup_pc_i[IDX:1];

  assign unused_pc = ^{res_pc_i[VLEN-1:IDX+1], res_pc_i[0],
                       lookup_pc_i[VLEN-1:IDX+1], lookup_pc_i[0]};

  assign ready_o          = idle;
  assign lookup_valid_o   = idle;
  assign lookup_taken_o   = idle & ctr_q[lkp_idx][1];
  assign mispredict_cnt_o = cnt_q;

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    unique case (state_q)
      INIT: begin
        init_idx_d = init_idx_q + idx_t'(1);
        if (init_idx_q == idx_t'(NR_ENTRIES - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        state_d = IDLE;
      end
    endcase
    if (flush_bp_i) begin
      state_d    = INIT;
      init_idx_d = '0;
    end
  end

  always_comb begin
    upd_v_d   = res_valid_i & res_is_branch_i & ~debug_mode_i
              & idle & ~flush_bp_i;
    upd_idx_d = res_idx;
    upd_tk_d  = res_is_taken_i;
  end

  // Init sweep owns the write port; otherwise stage 2 may use it.
  always_comb begin
    upd_ctr = ctr_q[upd_idx_q];
    wr_en   = 1'b0;
    wr_idx  = upd_idx_q;
    wr_data = upd_ctr;
    if (!idle) begin
      wr_en   = ~rst_i;
      wr_idx  = init_idx_q;
      wr_data = CTR_INIT;
    end else if (upd_v_q && !flush_bp_i && !rst_i) begin
      wr_en = 1'b1;
      if (upd_tk_q) begin
        wr_data = (upd_ctr == 2'd3) ? 2'd3 : upd_ctr + 2'd1;
      end else begin
        wr_data = (upd_ctr == 2'd0) ? 2'd0 : upd_ctr - 2'd1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (res_valid_i && res_is_mispredict_i && !debug_mode_i
        && cnt_q != 32'hFFFF_FFFF) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      upd_v_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      upd_v_q    <= upd_v_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    upd_idx_q <= upd_idx_d;
    upd_tk_q  <= upd_tk_d;
    if (wr_en) begin
      ctr_q[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_bht_update_unit.sv
// Directed bench for bht_update_unit with a table-level reference model
// compared against the outputs every cycle.
module tb_bht_update_unit;

  localparam int         VLEN = 39;
  localparam int         N    = 64;
  localparam logic [1:0] CI   = 2'b01;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            flush_bp_i;
  logic            debug_mode_i;
  logic            res_valid_i;
  logic [VLEN-1:0] res_pc_i;
  logic            res_is_branch_i;
  logic            res_is_taken_i;
  logic            res_is_mispredict_i;
  logic [VLEN-1:0] lookup_pc_i;
  logic            lookup_valid_o;
  logic            lookup_taken_o;
  logic            ready_o;
  logic [31:0]     mispredict_cnt_o;

  always #5 clk = ~clk;

  bht_update_unit #(
    .VLEN(VLEN),
    .NR_ENTRIES(N),
    .CTR_INIT(CI)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .flush_bp_i(flush_bp_i),
    .debug_mode_i(debug_mode_i),
    .res_valid_i(res_valid_i),
    .res_pc_i(res_pc_i),
    .res_is_branch_i(res_is_branch_i),
    .res_is_taken_i(res_is_taken_i),
    .res_is_mispredict_i(res_is_mispredict_i),
    .lookup_pc_i(lookup_pc_i),
    .lookup_valid_o(lookup_valid_o),
    .lookup_taken_o(lookup_taken_o),
    .ready_o(ready_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole-table view, pending updates kept with due cycle
  typedef struct {
    longint due;
    int     idx;
    bit     tk;
  } upd_t;

  int          mtab [N];
  int          busy;
  logic [31:0] mcnt;
  bit          started = 0;
  bit          was_ready;
  longint      cyc = 0;
  upd_t        pq [$];
  upd_t        u;

  function automatic int idx_of(input logic [VLEN-1:0] pc);
    return int'((pc >> 1) % N);
  endfunction

  always @(posedge clk) begin
    was_ready = started && (busy == 0);
    if (rst_i || flush_bp_i) begin
      foreach (mtab[i]) mtab[i] = int'(CI);
      busy = N;
      pq.delete();
    end else if (started) begin
      while (pq.size() > 0 && pq[0].due <= cyc) begin
        u = pq.pop_front();
        if (was_ready) begin
          if (u.tk) mtab[u.idx] = (mtab[u.idx] == 3) ? 3 : mtab[u.idx] + 1;
          else      mtab[u.idx] = (mtab[u.idx] == 0) ? 0 : mtab[u.idx] - 1;
        end
      end
      if (was_ready && res_valid_i && res_is_branch_i && !debug_mode_i)
        pq.push_back('{cyc + 1, idx_of(res_pc_i), res_is_taken_i});
      if (busy > 0) busy--;
    end
    if (rst_i) mcnt = '0;
    else if (started && res_valid_i && res_is_mispredict_i && !debug_mode_i
             && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 1;
    if (rst_i) started = 1;
    cyc++;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("ready", {31'd0, ready_o}, {31'd0, busy == 0});
      chk("lookup_valid", {31'd0, lookup_valid_o}, {31'd0, busy == 0});
      chk("lookup_taken", {31'd0, lookup_taken_o},
          (busy == 0) ? 32'((mtab[idx_of(lookup_pc_i)] >> 1) & 1) : 32'd0);
      chk("mispredict_cnt", mispredict_cnt_o, mcnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic v, input logic [VLEN-1:0] pc,
                         input logic br, input logic tk, input logic mis);
    res_valid_i         = v;
    res_pc_i            = pc;
    res_is_branch_i     = br;
    res_is_taken_i      = tk;
    res_is_mispredict_i = mis;
  endtask

  // Drive n consecutive resolutions, then one idle cycle; the next
  // negedge observes the last update.
  task automatic burst(input logic [VLEN-1:0] pc, input logic br,
                       input logic tk, input logic mis, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      set_res(1'b1, pc, br, tk, mis);
    end
    step();
    set_res(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    @(negedge clk);
  endtask

  // Counts not-ready cycles from the current one, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 300) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    rst_i        = 1'b1;
    flush_bp_i   = 1'b0;
    debug_mode_i = 1'b0;
    lookup_pc_i  = '0;
    set_res(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();

    // Initialisation after reset
    rst_i = 1'b0;
    wait_ready(n);
    chk("init_len_reset", n, 64);
    step();
    lookup_pc_i = 39'h80;
    @(negedge clk);
    chk("init_lookup_80", {31'd0, lookup_taken_o}, 0);
    step();
    lookup_pc_i = 39'h1234;
    @(negedge clk);
    chk("init_lookup_1234", {31'd0, lookup_taken_o}, 0);

    // Three consecutive taken updates of 0x80
    step();
    lookup_pc_i = 39'h80;
    set_res(1'b1, 39'h80, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    chk("tk3_t0", {31'd0, lookup_taken_o}, 0);
    step();
    @(negedge clk);
    chk("tk3_t1_prewrite", {31'd0, lookup_taken_o}, 0);
    step();
    @(negedge clk);
    chk("tk3_t2", {31'd0, lookup_taken_o}, 1);
    step();
    set_res(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("tk3_t3", {31'd0, lookup_taken_o}, 1);

    // Non-branch resolutions leave the table alone
    lookup_pc_i = 39'h2;
    burst(39'h2, 1'b0, 1'b1, 1'b0, 3);
    chk("nonbranch", {31'd0, lookup_taken_o}, 0);

    // Flush, then saturate at 0 and climb back
    step();
    flush_bp_i = 1'b1;
    step();
    flush_bp_i = 1'b0;
    wait_ready(n);
    chk("init_len_flush", n, 64);
    lookup_pc_i = 39'h100;
    burst(39'h100, 1'b1, 1'b0, 1'b0, 5);
    chk("nt5", {31'd0, lookup_taken_o}, 0);
    burst(39'h100, 1'b1, 1'b1, 1'b0, 1);
    chk("nt5_tk1", {31'd0, lookup_taken_o}, 0);
    burst(39'h100, 1'b1, 1'b1, 1'b0, 1);
    chk("nt5_tk2", {31'd0, lookup_taken_o}, 1);

    // Flush right behind a taken update of 0x40
    step();
    lookup_pc_i = 39'h40;
    set_res(1'b1, 39'h40, 1'b1, 1'b1, 1'b0);
    step();
    set_res(1'b0, '0, 1'b0, 1'b0, 1'b0);
    flush_bp_i = 1'b1;
    step();
    flush_bp_i = 1'b0;
    wait_ready(n);
    chk("init_len_flush2", n, 64);
    step();
    @(negedge clk);
    chk("flush_discard", {31'd0, lookup_taken_o}, 0);
    burst(39'h40, 1'b1, 1'b1, 1'b0, 1);
    chk("flush_ctr_init", {31'd0, lookup_taken_o}, 1);

    // Mispredict counting around debug mode and INIT
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    lookup_pc_i = 39'h80;
    debug_mode_i = 1'b1;
    set_res(1'b1, 39'h80, 1'b1, 1'b1, 1'b1);
    step();
    debug_mode_i = 1'b0;
    step();
    set_res(1'b0, '0, 1'b0, 1'b0, 1'b0);
    wait_ready(n);
    chk("init_len_reset2", n, 62);
    chk("mis_cnt_init", mispredict_cnt_o, 1);
    burst(39'h8, 1'b0, 1'b0, 1'b1, 1);
    chk("mis_cnt_2", mispredict_cnt_o, 2);
    chk("init_update_dropped", {31'd0, lookup_taken_o}, 0);
    burst(39'h80, 1'b1, 1'b1, 1'b0, 1);
    chk("init_update_ctr", {31'd0, lookup_taken_o}, 1);
    step();
    flush_bp_i = 1'b1;
    step();
    flush_bp_i = 1'b0;
    @(negedge clk);
    chk("mis_cnt_flush", mispredict_cnt_o, 2);
    wait_ready(n);

    // Counter saturation
    step();
    force dut.cnt_q = 32'hFFFF_FFFE;
    mcnt = 32'hFFFF_FFFE;
    step();
    release dut.cnt_q;
    burst(39'h10, 1'b0, 1'b0, 1'b1, 3);
    chk("mis_cnt_sat", mispredict_cnt_o, 32'hFFFF_FFFF);

    step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
